// File: rtl/demortl_pkg.sv
// Shared definitions for the demortl controller: in_packet header layout
// and the assembler state encoding.
package demortl_pkg;

    localparam int OPC_LSB     = 0;
    localparam int LEN_LSB     = 8;
    localparam int HDR_FIELD_W = 8;

    localparam logic [1:0] HDR  = 2'd0;
    localparam logic [1:0] PAY  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_HDR  = HDR,
        ST_PAY  = PAY,
        ST_HOLD = HOLD
    } asm_state_e;

    // A header length is usable only if it names between 1 and max_words payload words.
    function automatic logic hdr_len_ok(input logic [HDR_FIELD_W-1:0] len, input int max_words);
        return (len != '0) && (int'(len) <= max_words);
    endfunction

endpackage

// File: rtl/in_packet_assembler.sv
// Drains the in_packet FIFO and assembles header + payload words into one
// parallel request packet for the accelerator, with packet/error statistics.
module in_packet_assembler
    import demortl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WORDS  = 8,
    parameter int LEN_WIDTH  = $clog2(MAX_WORDS + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           fifo_dout,
    input  logic                            fifo_empty,
    output logic                            fifo_read_en,
    output logic                            pkt_valid,
    input  logic                            pkt_ready,
    output logic [7:0]                      pkt_opcode,
    output logic [LEN_WIDTH-1:0]            pkt_len,
    output logic [MAX_WORDS*DATA_WIDTH-1:0] pkt_data,
    output logic                            hdr_err,
    output logic [15:0]                     pkt_count,
    output logic [7:0]                      err_count
);

    asm_state_e                             state_q, state_d;
    logic                                   rd_pend_q, rd_pend_d;
    logic [7:0]                             opcode_q, opcode_d;
    logic [LEN_WIDTH-1:0]                   len_q, len_d;
    logic [LEN_WIDTH-1:0]                   issued_q, issued_d;
    logic [LEN_WIDTH-1:0]                   got_q, got_d;
    logic [MAX_WORDS-1:0][DATA_WIDTH-1:0]   data_q, data_d;
    logic [15:0]                            pkt_count_q, pkt_count_d;
    logic [7:0]                             err_count_q, err_count_d;

    logic                                   want;
    logic                                   read_fire;
    logic [HDR_FIELD_W-1:0]                 hdr_opc;
    logic [HDR_FIELD_W-1:0]                 hdr_len;
    logic                                   hdr_bad;

    assign hdr_opc = fifo_dout[OPC_LSB +: HDR_FIELD_W];
    assign hdr_len = fifo_dout[LEN_LSB +: HDR_FIELD_W];
    assign hdr_bad = !hdr_len_ok(hdr_len, MAX_WORDS);

    // Only one header read may be outstanding; payload reads stop at the packet boundary.
    always_comb begin
        want = 1'b0;
        unique case (state_q)
            ST_HDR:  want = !rd_pend_q;
            ST_PAY:  want = (issued_q < len_q);
            default: want = 1'b0;
        endcase
    end

    assign read_fire    = want && !fifo_empty && rst;
    assign fifo_read_en = read_fire;

    always_comb begin
        state_d     = state_q;
        rd_pend_d   = read_fire;
        opcode_d    = opcode_q;
        len_d       = len_q;
        issued_d    = issued_q;
        got_d       = got_q;
        data_d      = data_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        hdr_err     = 1'b0;

        unique case (state_q)
            ST_HDR: begin
                if (rd_pend_q) begin
                    if (hdr_bad) begin
                        hdr_err = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                    end else begin
                        opcode_d = hdr_opc;
                        len_d    = hdr_len[LEN_WIDTH-1:0];
                        issued_d = '0;
                        got_d    = '0;
                        data_d   = '0;
                        state_d  = ST_PAY;
                    end
                end
            end

            ST_PAY: begin
                if (read_fire) begin
                    issued_d = issued_q + LEN_WIDTH'(1);
                end
                // The word landing now belongs to the read issued last cycle.
                if (rd_pend_q) begin
                    for (int i = 0; i < MAX_WORDS; i++) begin
                        if (got_q == LEN_WIDTH'(i)) begin
                            data_d[i] = fifo_dout;
                        end
                    end
                    got_d = got_q + LEN_WIDTH'(1);
                    if (got_q == len_q - LEN_WIDTH'(1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (pkt_ready) begin
                    pkt_count_d = pkt_count_q + 16'd1;
                    data_d      = '0;
                    state_d     = ST_HDR;
                end
            end

            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_HDR;
            rd_pend_q   <= 1'b0;
            opcode_q    <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            got_q       <= '0;
            data_q      <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_pend_q   <= rd_pend_d;
            opcode_q    <= opcode_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            got_q       <= got_d;
            data_q      <= data_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign pkt_valid  = (state_q == ST_HOLD);
    assign pkt_opcode = opcode_q;
    assign pkt_len    = len_q;
    assign pkt_data   = data_q;
    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;

endmodule

// File: doc/in_packet_assembler.md
# in_packet_assembler

Drains 32-bit words from the `in_packet` `fifo_buffer` in the demortl controller and assembles them into complete request packets for the accelerator. Each packet is one header word followed by N payload words. The block drives the FIFO's `read_en`, tracks the FIFO's one-cycle registered read latency, and parses the header. It presents the whole packet in parallel on a valid/ready interface and keeps packet and error statistics.

## Interface
Parameters:
- DATA_WIDTH, 32, FIFO word width; must match the upstream FIFO.
- MAX_WORDS, 8, maximum payload words per packet (≥1).
- LEN_WIDTH, $clog2(MAX_WORDS+1), width of the length fields.

Ports:
- clk  in  1  Single clock; everything is on posedge.
- rst  in  1  Asynchronous, active-low reset.
- fifo_dout  in  DATA_WIDTH  FIFO registered output; valid the cycle after a read fire.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_en  out  1  FIFO pop request; combinational.
- pkt_valid  out  1  Assembled packet available.
- pkt_ready  in  1  Accelerator accepts the packet.
- pkt_opcode  out  8  Header bits [7:0].
- pkt_len  out  LEN_WIDTH  Payload word count, 1..MAX_WORDS.
- pkt_data  out  MAX_WORDS*DATA_WIDTH  Payload word i is at [i*DATA_WIDTH +: DATA_WIDTH]; unused words are 0.
- hdr_err  out  1  One-cycle pulse when a header is dropped.
- pkt_count  out  16  Accepted packets; wraps.
- err_count  out  8  Dropped headers; saturates at 255.

## Operation
- Header format: [7:0] opcode; [15:8] length; [DATA_WIDTH-1:16] ignored.
- Read fire: `fifo_read_en` is high only when the block wants a word and `fifo_empty` is 0. It is forced to 0 while `rst` is low.
- `rd_pend` is a register that equals the read fire of the previous cycle. It marks the cycle in which `fifo_dout` holds the new word.
- States:
  - HDR (reset state): want = !rd_pend. When rd_pend is set, latch the opcode and length.
    - Length 0 or length > MAX_WORDS: pulse `hdr_err`, increment `err_count` (saturating), stay in HDR.
    - Otherwise: clear `issued` and `got`, go to PAY.
  - PAY: want = issued < len. Each read fire increments `issued`. Each rd_pend writes `fifo_dout` into payload slot `got` and increments `got`. When the final word is captured (got == len−1 and rd_pend), go to HOLD.
  - HOLD: `pkt_valid` = 1 and want = 0. On `pkt_valid && pkt_ready`: increment `pkt_count`, zero `pkt_data`, go to HDR.
- `pkt_opcode`, `pkt_len` and `pkt_data` are stable throughout HOLD.
- Arithmetic: `issued` and `got` are LEN_WIDTH bits and never exceed `len`. `pkt_count` is modulo 2^16.

## Timing
- Reset values: `fifo_read_en` 0, `pkt_valid` 0, `pkt_opcode` 0, `pkt_len` 0, `pkt_data` 0, `hdr_err` 0, `pkt_count` 0, `err_count` 0; state HDR; `rd_pend` 0.
- Latency with the FIFO continuously non-empty:
  - Cycle 0: header read fires.
  - Cycle 1: header parsed.
  - Cycles 2..N+1: payload reads fire.
  - Cycles 3..N+2: payload words captured.
  - Cycle N+3: `pkt_valid` rises.
- Payload reads run back-to-back; there are no bubbles unless the FIFO goes empty.
- FIFO empty during PAY: reads stall and `issued` holds. Capture continues for the read already in flight.
- The block never reads beyond the current packet boundary; the next header stays in the FIFO.
- `pkt_ready` held high when `pkt_valid` rises: accepted in that same cycle. The next header read can fire one cycle later.
- `pkt_ready` low: the block holds indefinitely and issues no reads (backpressure).
- Bad header: `hdr_err` pulses for exactly one cycle. The next header read fires in the cycle after the error, so there is at most 1 cycle between successive headers.
- Reset asserted mid-packet: all state clears immediately and the partial packet is discarded. The FIFO shares the reset, so no stale words remain.

## Structure
- Shared package `demortl_pkg` holds:
  - the header field offsets and widths (OPC_LSB 0, LEN_LSB 8, field width 8);
  - the state encoding localparams HDR=2'd0, PAY=2'd1, HOLD=2'd2.
- The RTL is a single module with no sub-module. The payload register array is inline, written by slot index.

## Test plan
- Header opcode 0x12, length 3, then payload 0xA, 0xB, 0xC, with `pkt_ready` held 1 → `pkt_valid` rises at cycle 6 after the first read fire; `pkt_data` word0..2 = A, B, C; word3..7 = 0; `pkt_count` = 1.
- Header with length 0, followed by a valid length-1 packet (payload 0x55) → `hdr_err` pulses once, `err_count` = 1; the second packet is delivered with word0 = 0x55.
- Header with length 9 (MAX_WORDS = 8) → dropped, `err_count` increments; exactly one FIFO word is consumed.
- FIFO goes empty for 5 cycles partway through a length-4 payload → `fifo_read_en` is 0 during the gap; all 4 words arrive in order.
- Two back-to-back packets with `pkt_ready` low for 10 cycles → `pkt_valid` and data are stable for those 10 cycles, and no `fifo_read_en` fires until acceptance.
- `rst` pulsed low while 2 of 5 payload words have been captured → all outputs are 0 immediately; the next packet assembles correctly.
